ahb_slave_mem: RTL and testbench

- AHB slave memory model. It is the responder for the DMA master, which drives HADDR/HTRANS/HSIZE/HWRITE/HWDATA and consumes HRDATA/HREADY.
- Holds frame or pixel data in a word-addressed array.
- Inserts programmable wait states and returns a two-cycle ERROR response for illegal transfers.
- Used in the system bench and as the on-chip frame buffer behind the bus.

---
 rtl/ahb_pkg.sv | 24 ++
 rtl/ahb_byte_lane.sv | 32 +++
 rtl/ahb_slave_mem.sv | 130 +++++++++++++
 tb/tb_ahb_slave_mem.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB encodings and slave FSM state type for the AHB slave memory.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_e;

endpackage

// File: rtl/ahb_byte_lane.sv
// Byte-lane strobe and alignment check for one AHB transfer (little-endian lanes).
module ahb_byte_lane
    import ahb_pkg::*;
(
    input  logic [2:0] size_i,
    input  logic [1:0] addr_i,
    output logic [3:0] strb_o,
    output logic       legal_o
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        strb_o  = 4'b0000;
        legal_o = 1'b0;
        case (size_i)
            HSIZE_BYTE: begin
                strb_o  = 4'b0001 << addr_i;
                legal_o = 1'b1;
            end
            HSIZE_HALF: begin
                strb_o  = addr_i[1] ? 4'b1100 : 4'b0011;
                legal_o = !addr_i[0];
            end
            HSIZE_WORD: begin
                strb_o  = 4'b1111;
                legal_o = (addr_i == 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB slave memory: word array with programmable wait states and two-cycle ERROR response.
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int          MEM_WORDS = 1024,
    parameter int          WAIT_NS   = 1,
    parameter int          WAIT_SEQ  = 0
) (
    input  logic        I_SMEM_HCLK,
    input  logic        I_SMEM_RESET,
    input  logic        I_SMEM_HSEL,
    input  logic [31:0] I_SMEM_HADDR,
    input  logic [1:0]  I_SMEM_HTRANS,
    input  logic        I_SMEM_HWRITE,
    input  logic [2:0]  I_SMEM_HSIZE,
    input  logic [2:0]  I_SMEM_HBURST,
    input  logic [31:0] I_SMEM_HWDATA,
    output logic [31:0] O_SMEM_HRDATA,
    output logic        O_SMEM_HREADY,
    output logic [1:0]  O_SMEM_HRESP,
    output logic [7:0]  O_SMEM_ERR_CNT
);

    localparam int          IDX_W      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [31:0] SPAN       = 32'(4 * MEM_WORDS);
    localparam logic [3:0]  WAITS_NS_C = 4'(WAIT_NS);
    localparam logic [3:0]  WAITS_SQ_C = 4'(WAIT_SEQ);

    state_e           state_q, state_d;
    logic [3:0]       wait_q, wait_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]       strb_q, strb_d;
    logic             write_q, write_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic [31:0]      mem [MEM_WORDS];

    logic [32:0] offset;
    logic [3:0]  lane_strb;
    logic        lane_legal;
    logic        in_range, legal, sample;
    logic [3:0]  waits;
    logic        unused_burst;

    // HBURST carries no decode information here; addresses come from HADDR.
    assign unused_burst = ^I_SMEM_HBURST;

    ahb_byte_lane u_lane (
        .size_i  (I_SMEM_HSIZE),
        .addr_i  (I_SMEM_HADDR[1:0]),
        .strb_o  (lane_strb),
        .legal_o (lane_legal)
    );

    // Bit 32 is the borrow: set when HADDR lies below ADDR_BASE.
    assign offset   = {1'b0, I_SMEM_HADDR} - {1'b0, ADDR_BASE};
    assign in_range = !offset[32] && (offset[31:0] < SPAN);
    assign legal    = lane_legal && in_range;
    assign waits    = I_SMEM_HTRANS[0] ? WAITS_SQ_C : WAITS_NS_C;

    assign O_SMEM_HREADY  = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
    assign O_SMEM_HRESP   = (state_q == ST_ERR1 || state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    assign O_SMEM_HRDATA  = (state_q == ST_DATA && !write_q) ? mem[idx_q] : 32'h0;
    assign O_SMEM_ERR_CNT = err_cnt_q;
    assign sample         = O_SMEM_HREADY && I_SMEM_HSEL && I_SMEM_HTRANS[1];

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        idx_d     = idx_q;
        strb_d    = strb_q;
        write_d   = write_q;
        err_cnt_d = err_cnt_q;
        case (state_q)
            ST_WAIT: begin
                wait_d = wait_q - 4'd1;
                if (wait_q == 4'd1) state_d = ST_DATA;
            end
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            default: ;
        endcase
        // Any cycle completing with HREADY high is also an address phase.
        if (O_SMEM_HREADY) begin
            state_d = ST_IDLE;
            if (sample) begin
                idx_d   = offset[IDX_W+1:2];
                strb_d  = lane_strb;
                write_d = I_SMEM_HWRITE;
                if (!legal) begin
                    state_d = ST_ERR1;
                end else if (waits != 4'd0) begin
                    state_d = ST_WAIT;
                    wait_d  = waits;
                end else begin
                    state_d = ST_DATA;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge I_SMEM_HCLK) begin
        if (I_SMEM_RESET) begin
            state_q   <= ST_IDLE;
            wait_q    <= 4'd0;
            idx_q     <= '0;
            strb_q    <= 4'd0;
            write_q   <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            idx_q     <= idx_d;
            strb_q    <= strb_d;
            write_q   <= write_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // NOTE: the array has no reset; contents survive reset and map onto plain RAM.
    always_ff @(posedge I_SMEM_HCLK) begin
        if (!I_SMEM_RESET && state_q == ST_DATA && write_q) begin
            for (int b = 0; b < 4; b++) begin
                if (strb_q[b]) mem[idx_q][8*b +: 8] <= I_SMEM_HWDATA[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Self-checking bench for ahb_slave_mem: transfer-level model plus directed and random traffic.
module tb_ahb_slave_mem;
    import ahb_pkg::*;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          WORDS = 1024;
    localparam int          WNS   = 1;
    localparam int          WSEQ  = 0;
    localparam int          GUARD = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hsel = 1'b0;
    logic [31:0] haddr = 32'h0;
    logic [1:0]  htrans = HTRANS_IDLE;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = HSIZE_WORD;
    logic [2:0]  hburst = 3'b000;
    logic [31:0] hwdata = 32'h0;
    logic [31:0] hrdata;
    logic        hready;
    logic [1:0]  hresp;
    logic [7:0]  err_cnt;

    ahb_slave_mem #(
        .ADDR_BASE (BASE),
        .MEM_WORDS (WORDS),
        .WAIT_NS   (WNS),
        .WAIT_SEQ  (WSEQ)
    ) dut (
        .I_SMEM_HCLK    (clk),
        .I_SMEM_RESET   (rst),
        .I_SMEM_HSEL    (hsel),
        .I_SMEM_HADDR   (haddr),
        .I_SMEM_HTRANS  (htrans),
        .I_SMEM_HWRITE  (hwrite),
        .I_SMEM_HSIZE   (hsize),
        .I_SMEM_HBURST  (hburst),
        .I_SMEM_HWDATA  (hwdata),
        .O_SMEM_HRDATA  (hrdata),
        .O_SMEM_HREADY  (hready),
        .O_SMEM_HRESP   (hresp),
        .O_SMEM_ERR_CNT (err_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transfer-level reference model ----------------
    bit [31:0]   mdl_mem [int];
    bit          mdl_valid = 0;
    bit          ph_active = 0;
    bit          ph_err    = 0;
    bit          ph_write  = 0;
    int          ph_stall  = 0;
    int          ph_idx    = 0;
    int          ph_lo     = 0;
    int          ph_bytes  = 0;
    int          mdl_err   = 0;
    logic [31:0] rd_log[$];

    function automatic bit legal_xfer(input bit [31:0] a, input bit [2:0] s);
        longint off;
        off = longint'({32'h0, a}) - longint'({32'h0, BASE});
        if (s > 3'd2) return 1'b0;
        if ((a % (32'd1 << s)) != 0) return 1'b0;
        return (off >= 0) && (off < 4 * WORDS);
    endfunction

    // A data phase lasts ph_stall low-HREADY cycles followed by one completing cycle.
    always @(posedge clk) begin
        bit         rdy;
        bit [31:0]  w;
        if (rst) begin
            mdl_valid = 1;
            ph_active = 0;
            mdl_err   = 0;
        end else if (mdl_valid) begin
            rdy = !ph_active || ph_stall == 0;
            if (ph_active) begin
                if (ph_stall > 0) begin
                    ph_stall--;
                end else begin
                    if (ph_err) begin
                        mdl_err = (mdl_err < 255) ? mdl_err + 1 : 255;
                    end else if (ph_write && (ph_bytes == 4 || mdl_mem.exists(ph_idx))) begin
                        w = mdl_mem.exists(ph_idx) ? mdl_mem[ph_idx] : 32'h0;
                        for (int b = 0; b < ph_bytes; b++)
                            w[8*(ph_lo+b) +: 8] = hwdata[8*(ph_lo+b) +: 8];
                        mdl_mem[ph_idx] = w;
                    end
                    ph_active = 0;
                end
            end
            if (rdy && hsel && htrans[1]) begin
                ph_active = 1;
                ph_write  = hwrite;
                ph_err    = !legal_xfer(haddr, hsize);
                ph_idx    = int'((haddr - BASE) >> 2);
                ph_lo     = int'(haddr[1:0]);
                ph_bytes  = 1 << hsize;
                ph_stall  = ph_err ? 1 : (htrans[0] ? WSEQ : WNS);
            end
        end
    end

    // Compare every cycle once the model has seen a reset.
    always @(negedge clk) begin
        bit rd_cyc;
        if (mdl_valid) begin
            rd_cyc = ph_active && !ph_err && !ph_write && ph_stall == 0;
            check("hready", 32'(hready), 32'(!ph_active || ph_stall == 0));
            check("hresp", 32'(hresp), (ph_active && ph_err) ? 32'd1 : 32'd0);
            check("err_cnt", 32'(err_cnt), 32'(mdl_err));
            if (!rd_cyc) begin
                check("hrdata_idle", hrdata, 32'h0);
            end else begin
                if (mdl_mem.exists(ph_idx)) check("hrdata", hrdata, mdl_mem[ph_idx]);
                rd_log.push_back(hrdata);
            end
        end
    end

    // ---------------- pipelined master driver ----------------
    typedef struct {
        bit        sel;
        bit [1:0]  trans;
        bit [31:0] addr;
        bit        write;
        bit [2:0]  size;
        bit [31:0] wdata;
    } beat_t;

    beat_t beats[$];

    task automatic add(input bit sel, input bit [1:0] trans, input bit [31:0] addr,
                       input bit write, input bit [2:0] size, input bit [31:0] wdata);
        beat_t b;
        b.sel = sel; b.trans = trans; b.addr = addr;
        b.write = write; b.size = size; b.wdata = wdata;
        beats.push_back(b);
    endtask

    task automatic wait_accept(input string what);
        int   n = 0;
        logic r;
        do begin
            @(negedge clk);
            r = hready;
            @(posedge clk);
            #1;
            n++;
        end while (r !== 1'b1 && n < GUARD);
        if (r !== 1'b1) check({what, "_accept_timeout"}, 32'(r), 32'd1);
    endtask

    task automatic run();
        beat_t b;
        while (beats.size() > 0) begin
            b = beats.pop_front();
            hsel = b.sel; htrans = b.trans; haddr = b.addr;
            hwrite = b.write; hsize = b.size;
            wait_accept("beat");
            hwdata = b.wdata;
        end
        hsel = 1'b0;
        htrans = HTRANS_IDLE;
        wait_accept("drain");
    endtask

    task automatic expect_rd(input string name, input logic [31:0] v);
        logic [31:0] a;
        a = 'x;
        if (rd_log.size() > 0) a = rd_log.pop_front();
        check(name, a, v);
    endtask

    initial begin
        int c0;
        bit [31:0] a;
        bit [2:0]  s;
        bit [1:0]  t;

        // Reset
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_hready", 32'(hready), 32'd1);
        check("rst_hresp", 32'(hresp), 32'd0);
        check("rst_hrdata", hrdata, 32'h0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        @(posedge clk); #1;

        // NONSEQ word write then read back: 1 wait each
        rd_log.delete();
        c0 = cyc;
        add(1, HTRANS_NONSEQ, BASE + 32'h10, 1, HSIZE_WORD, 32'hCAFEBABE);
        add(1, HTRANS_NONSEQ, BASE + 32'h10, 0, HSIZE_WORD, 32'h0);
        run();
        check("wr_rd_cycles", 32'(cyc - c0), 32'd5);
        expect_rd("rb_cafebabe", 32'hCAFEBABE);

        // INCR4 read, NONSEQ wait then 1 beat/cycle
        add(1, HTRANS_NONSEQ, BASE + 32'h0, 1, HSIZE_WORD, 32'd1);
        add(1, HTRANS_SEQ,    BASE + 32'h4, 1, HSIZE_WORD, 32'd2);
        add(1, HTRANS_SEQ,    BASE + 32'h8, 1, HSIZE_WORD, 32'd3);
        add(1, HTRANS_SEQ,    BASE + 32'hC, 1, HSIZE_WORD, 32'd4);
        run();
        rd_log.delete();
        c0 = cyc;
        add(1, HTRANS_NONSEQ, BASE + 32'h0, 0, HSIZE_WORD, 32'h0);
        add(1, HTRANS_SEQ,    BASE + 32'h4, 0, HSIZE_WORD, 32'h0);
        add(1, HTRANS_SEQ,    BASE + 32'h8, 0, HSIZE_WORD, 32'h0);
        add(1, HTRANS_SEQ,    BASE + 32'hC, 0, HSIZE_WORD, 32'h0);
        run();
        check("incr4_cycles", 32'(cyc - c0), 32'd6);
        expect_rd("incr4_0", 32'd1);
        expect_rd("incr4_1", 32'd2);
        expect_rd("incr4_2", 32'd3);
        expect_rd("incr4_3", 32'd4);

        // Sub-word writes
        rd_log.delete();
        add(1, HTRANS_NONSEQ, BASE + 32'h0, 1, HSIZE_WORD, 32'h11223344);
        add(1, HTRANS_NONSEQ, BASE + 32'h3, 1, HSIZE_BYTE, 32'hAAAAAAAA);
        add(1, HTRANS_NONSEQ, BASE + 32'h0, 0, HSIZE_WORD, 32'h0);
        add(1, HTRANS_NONSEQ, BASE + 32'h2, 1, HSIZE_HALF, 32'hBEEFBEEF);
        add(1, HTRANS_NONSEQ, BASE + 32'h0, 0, HSIZE_WORD, 32'h0);
        run();
        expect_rd("byte_wr", 32'hAA223344);
        expect_rd("half_wr", 32'hBEEF3344);

        // Illegal transfers: misaligned, out of range, bad size
        rd_log.delete();
        add(1, HTRANS_NONSEQ, BASE + 32'h2, 1, HSIZE_WORD, 32'hDEADDEAD);
        run();
        check("err_cnt_1", 32'(err_cnt), 32'd1);
        add(1, HTRANS_NONSEQ, BASE + 32'h0, 0, HSIZE_WORD, 32'h0);
        add(1, HTRANS_NONSEQ, BASE + 32'(4 * WORDS), 0, HSIZE_WORD, 32'h0);
        add(1, HTRANS_NONSEQ, BASE + 32'h0, 1, 3'b011, 32'h0);
        run();
        expect_rd("err_mem_unchanged", 32'hBEEF3344);
        check("err_cnt_3", 32'(err_cnt), 32'd3);

        // BUSY / HSEL=0 produce no access; write then immediate read
        rd_log.delete();
        add(1, HTRANS_NONSEQ, BASE + 32'h3C, 1, HSIZE_WORD, 32'h3C3C3C3C);
        add(1, HTRANS_BUSY,   BASE + 32'h3C, 1, HSIZE_WORD, 32'hBAD0BAD0);
        add(0, HTRANS_NONSEQ, BASE + 32'h3C, 1, HSIZE_WORD, 32'hBAD1BAD1);
        add(1, HTRANS_SEQ,    BASE + 32'h38, 1, HSIZE_WORD, 32'h77777777);
        add(1, HTRANS_NONSEQ, BASE + 32'h38, 0, HSIZE_WORD, 32'h0);
        add(1, HTRANS_NONSEQ, BASE + 32'h3C, 0, HSIZE_WORD, 32'h0);
        run();
        expect_rd("raw_same_word", 32'h77777777);
        expect_rd("busy_nosel_no_write", 32'h3C3C3C3C);

        // Reset during the wait state of a write
        add(1, HTRANS_NONSEQ, BASE + 32'h40, 1, HSIZE_WORD, 32'h5A5A5A5A);
        run();
        hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = BASE + 32'h40;
        hwrite = 1'b1; hsize = HSIZE_WORD;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'hDEADBEEF; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_hready", 32'(hready), 32'd1);
        check("midrst_hresp", 32'(hresp), 32'd0);
        check("midrst_hrdata", hrdata, 32'h0);
        check("midrst_err_cnt", 32'(err_cnt), 32'd0);
        rd_log.delete();
        add(1, HTRANS_NONSEQ, BASE + 32'h40, 0, HSIZE_WORD, 32'h0);
        run();
        expect_rd("midrst_discard", 32'h5A5A5A5A);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0:       t = HTRANS_IDLE;
                1:       t = HTRANS_BUSY;
                2, 3, 4: t = HTRANS_NONSEQ;
                default: t = HTRANS_SEQ;
            endcase
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: a = BASE + 32'($urandom_range(0, 63));
                6, 7:             a = BASE + 32'(4 * WORDS - 16) + 32'($urandom_range(0, 15));
                8:                a = BASE + 32'(4 * WORDS) + 32'($urandom_range(0, 31));
                default:          a = BASE + 32'($urandom_range(0, 4 * WORDS - 1));
            endcase
            s = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            if (s <= 3'd2 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << s) - 32'd1);
            add($urandom_range(0, 9) != 0, t, a, 1'($urandom_range(0, 1)), s, $urandom);
        end
        run();

        // Error counter saturation
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 260; i++)
            add(1, HTRANS_NONSEQ, BASE + 32'h1, 0, HSIZE_WORD, 32'h0);
        run();
        check("err_cnt_saturate", 32'(err_cnt), 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
